// File: rtl/axi_lite_rf_ctrl.sv
// axi_lite_rf_ctrl
// AXI4-Lite slave that bridges single-beat writes and reads onto a simple
// register-file port (one-cycle write strobe, combinational read data).
// Independent write and read FSMs; both may be busy in the same cycle.
//
// Ports:
//   i_clock, i_aresetn                 clock, asynchronous active-low reset
//   i_awaddr/i_awvalid/o_awready       AW channel
//   i_wdata/i_wvalid/o_wready          W channel
//   o_bresp/o_bvalid/i_bready          B channel
//   i_araddr/i_arvalid/o_arready       AR channel
//   o_rdata/o_rresp/o_rvalid/i_rready  R channel
//   o_rf_write_addr/_data/_enable      register-file write port
//   o_rf_read_addr/_enable, i_rf_read_data  register-file read port
//
// Build option: define AXI_RF_SLVERR_EN to reject unmapped addresses
// (anything not word-aligned or above 0xC) with SLVERR and no register-file
// access. Without it every access is forwarded and answered OKAY.
module axi_lite_rf_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_aresetn,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_rvalid,
    input  logic                  i_rready,
    output logic [ADDR_WIDTH-1:0] o_rf_write_addr,
    output logic [DATA_WIDTH-1:0] o_rf_write_data,
    output logic                  o_rf_write_enable,
    output logic [ADDR_WIDTH-1:0] o_rf_read_addr,
    output logic                  o_rf_read_enable,
    input  logic [DATA_WIDTH-1:0] i_rf_read_data
);

`ifdef AXI_RF_SLVERR_EN
    localparam logic SLVERR_EN = 1'b1;
`else
    localparam logic SLVERR_EN = 1'b0;
`endif
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WRITE = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_READ = 2'd1, R_RESP = 2'd2} r_state_t;

    // Word-aligned and within the four-register window 0x0..0xC.
    function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr <= ADDR_WIDTH'(4'hC));
    endfunction

    // Access is forwarded to the register file unless rejection is enabled and the address is unmapped.
    function automatic logic addr_forward(input logic [ADDR_WIDTH-1:0] addr);
        return (!SLVERR_EN) || addr_mapped(addr);
    endfunction

    w_state_t              w_state_r, w_state_s;
    logic                  awready_r, awready_s, wready_r, wready_s;
    logic                  aw_held_r, aw_held_s, w_held_r, w_held_s;
    logic [ADDR_WIDTH-1:0] waddr_r, waddr_s;
    logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
    logic                  we_r, we_s, bvalid_r, bvalid_s;
    logic [1:0]            bresp_r, bresp_s;

    r_state_t              r_state_r, r_state_s;
    logic                  arready_r, arready_s, re_r, re_s, rvalid_r, rvalid_s;
    logic [ADDR_WIDTH-1:0] raddr_r, raddr_s;
    logic [DATA_WIDTH-1:0] rdata_r, rdata_s;
    logic [1:0]            rresp_r, rresp_s;

    // Write FSM next state: capture AW and W independently, strobe the register file once both are held.
    always_comb begin
        w_state_s = w_state_r;
        awready_s = awready_r;
        wready_s  = wready_r;
        aw_held_s = aw_held_r;
        w_held_s  = w_held_r;
        waddr_s   = waddr_r;
        wdata_s   = wdata_r;
        we_s      = 1'b0;
        bvalid_s  = bvalid_r;
        bresp_s   = bresp_r;
        case (w_state_r)
            W_IDLE: begin
                if (i_awvalid && awready_r) begin
                    waddr_s   = i_awaddr;
                    aw_held_s = 1'b1;
                end else begin
                    aw_held_s = aw_held_r;
                end
                if (i_wvalid && wready_r) begin
                    wdata_s  = i_wdata;
                    w_held_s = 1'b1;
                end else begin
                    w_held_s = w_held_r;
                end
                if (aw_held_s && w_held_s) begin
                    w_state_s = W_WRITE;
                    we_s      = addr_forward(waddr_s);
                    aw_held_s = 1'b0;
                    w_held_s  = 1'b0;
                    awready_s = 1'b0;
                    wready_s  = 1'b0;
                end else begin
                    // Ready stays high only for a channel not yet captured; also raises both after reset.
                    awready_s = !aw_held_s;
                    wready_s  = !w_held_s;
                end
            end
            W_WRITE: begin
                w_state_s = W_RESP;
                bvalid_s  = 1'b1;
                bresp_s   = addr_forward(waddr_r) ? RESP_OKAY : RESP_SLVERR;
            end
            W_RESP: begin
                if (i_bready) begin
                    w_state_s = W_IDLE;
                    bvalid_s  = 1'b0;
                    bresp_s   = RESP_OKAY;
                    awready_s = 1'b1;
                    wready_s  = 1'b1;
                end else begin
                    w_state_s = W_RESP;
                end
            end
            default: begin
                w_state_s = W_IDLE;
                awready_s = 1'b0;
                wready_s  = 1'b0;
                aw_held_s = 1'b0;
                w_held_s  = 1'b0;
                bvalid_s  = 1'b0;
                bresp_s   = RESP_OKAY;
            end
        endcase
    end

    // Write FSM state and output registers.
    always_ff @(posedge i_clock or negedge i_aresetn) begin
        if (!i_aresetn) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            waddr_r   <= '0;
            wdata_r   <= '0;
            we_r      <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            w_state_r <= w_state_s;
            awready_r <= awready_s;
            wready_r  <= wready_s;
            aw_held_r <= aw_held_s;
            w_held_r  <= w_held_s;
            waddr_r   <= waddr_s;
            wdata_r   <= wdata_s;
            we_r      <= we_s;
            bvalid_r  <= bvalid_s;
            bresp_r   <= bresp_s;
        end
    end

    // Read FSM next state: the register file answers combinationally while re_r is high; that value is registered into rdata.
    always_comb begin
        r_state_s = r_state_r;
        arready_s = arready_r;
        raddr_s   = raddr_r;
        re_s      = 1'b0;
        rvalid_s  = rvalid_r;
        rdata_s   = rdata_r;
        rresp_s   = rresp_r;
        case (r_state_r)
            R_IDLE: begin
                if (i_arvalid && arready_r) begin
                    r_state_s = R_READ;
                    raddr_s   = i_araddr;
                    arready_s = 1'b0;
                    re_s      = addr_forward(i_araddr);
                end else begin
                    arready_s = 1'b1;
                end
            end
            R_READ: begin
                r_state_s = R_RESP;
                rvalid_s  = 1'b1;
                if (re_r) begin
                    rdata_s = i_rf_read_data;
                    rresp_s = RESP_OKAY;
                end else begin
                    rdata_s = '0;
                    rresp_s = RESP_SLVERR;
                end
            end
            R_RESP: begin
                if (i_rready) begin
                    r_state_s = R_IDLE;
                    rvalid_s  = 1'b0;
                    rdata_s   = '0;
                    rresp_s   = RESP_OKAY;
                    arready_s = 1'b1;
                end else begin
                    r_state_s = R_RESP;
                end
            end
            default: begin
                r_state_s = R_IDLE;
                arready_s = 1'b0;
                rvalid_s  = 1'b0;
                rdata_s   = '0;
                rresp_s   = RESP_OKAY;
            end
        endcase
    end

    // Read FSM state and output registers.
    always_ff @(posedge i_clock or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            raddr_r   <= '0;
            re_r      <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_state_s;
            arready_r <= arready_s;
            raddr_r   <= raddr_s;
            re_r      <= re_s;
            rvalid_r  <= rvalid_s;
            rdata_r   <= rdata_s;
            rresp_r   <= rresp_s;
        end
    end

    assign o_awready         = awready_r;
    assign o_wready          = wready_r;
    assign o_bvalid          = bvalid_r;
    assign o_bresp           = bresp_r;
    assign o_rf_write_addr   = waddr_r;
    assign o_rf_write_data   = wdata_r;
    assign o_rf_write_enable = we_r;
    assign o_arready         = arready_r;
    assign o_rvalid          = rvalid_r;
    assign o_rdata           = rdata_r;
    assign o_rresp           = rresp_r;
    assign o_rf_read_addr    = raddr_r;
    assign o_rf_read_enable  = re_r;

endmodule

// File: tb/tb_axi_lite_rf_ctrl.sv
// Self-checking bench for axi_lite_rf_ctrl. The bench plays the register
// file and keeps a reference array of its expected contents.
module tb_axi_lite_rf_ctrl;

`ifdef AXI_RF_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = 4'h0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = 32'h0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = 4'h0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_we;
    logic [3:0]  rf_raddr;
    logic        rf_re;
    logic [31:0] rf_rdata;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Register-file emulation
    logic [31:0] rf_mem [16];
    logic        rf_load = 1'b0;
    logic [3:0]  load_addr = 4'h0;
    logic [31:0] load_data = 32'h0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;

    // Reference model of register-file contents
    logic [31:0] model_mem [16];

    always #5 clk = ~clk;

    axi_lite_rf_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .i_clock(clk), .i_aresetn(rst_n),
        .i_awaddr(awaddr), .i_awvalid(awvalid), .o_awready(awready),
        .i_wdata(wdata), .i_wvalid(wvalid), .o_wready(wready),
        .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
        .i_araddr(araddr), .i_arvalid(arvalid), .o_arready(arready),
        .o_rdata(rdata), .o_rresp(rresp), .o_rvalid(rvalid), .i_rready(rready),
        .o_rf_write_addr(rf_waddr), .o_rf_write_data(rf_wdata), .o_rf_write_enable(rf_we),
        .o_rf_read_addr(rf_raddr), .o_rf_read_enable(rf_re), .i_rf_read_data(rf_rdata)
    );

    assign rf_rdata = rf_mem[rf_raddr];

    // Register file storage, write strobe and read strobe counters
    always @(posedge clk) begin
        if (rf_load) rf_mem[load_addr] <= load_data;
        else if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
        if (rf_we) wr_cnt <= wr_cnt + 1;
        if (rf_re) rd_cnt <= rd_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit fwd(input logic [3:0] a);
        return !SLV || (a[1:0] == 2'b00 && a <= 4'hC);
    endfunction

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        rf_load = 1'b1; load_addr = a; load_data = d;
        tick();
        rf_load = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(); tick();
        chk_cnt++; if ({awready, wready, arready} !== 3'b000) $display("FAIL reset_readies: got %b want 000", {awready, wready, arready}); else pass_cnt++;
        chk_cnt++; if ({bvalid, rvalid, rf_we, rf_re} !== 4'b0000) $display("FAIL reset_valids: got %b want 0000", {bvalid, rvalid, rf_we, rf_re}); else pass_cnt++;
        chk_cnt++; if ({rdata, bresp, rresp} !== 36'h0) $display("FAIL reset_data: got %h want 0", {rdata, bresp, rresp}); else pass_cnt++;
        rst_n = 1'b1;
        tick();
        chk_cnt++; if ({awready, wready, arready} !== 3'b111) $display("FAIL release_readies: got %b want 111", {awready, wready, arready}); else pass_cnt++;
        for (int i = 0; i < 16; i++) preload(i[3:0], 32'h0);
    endtask

    task automatic test_same_cycle;
        int c0;
        c0 = wr_cnt;
        awaddr = 4'h4; awvalid = 1'b1; wdata = 32'hDEADBEEF; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk_cnt++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'h4, 32'hDEADBEEF}) $display("FAIL same_cycle_we: got %b %h %h want 1 4 deadbeef", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
        chk_cnt++; if (bvalid !== 1'b0) $display("FAIL same_cycle_bvalid_early: got %b want 0", bvalid); else pass_cnt++;
        tick();
        chk_cnt++; if ({rf_we, bvalid, bresp} !== 4'b0100) $display("FAIL same_cycle_resp: got we=%b bvalid=%b bresp=%b want 0 1 00", rf_we, bvalid, bresp); else pass_cnt++;
        tick();
        bready = 1'b0;
        chk_cnt++; if ({bvalid, awready, wready} !== 3'b011) $display("FAIL same_cycle_idle: got %b want 011", {bvalid, awready, wready}); else pass_cnt++;
        chk_cnt++; if (wr_cnt !== c0 + 1) $display("FAIL same_cycle_count: got %0d want %0d", wr_cnt - c0, 1); else pass_cnt++;
        model_mem[4] = 32'hDEADBEEF;
    endtask

    task automatic test_w_before_aw;
        int c0;
        c0 = wr_cnt;
        wdata = 32'h12345678; wvalid = 1'b1; bready = 1'b0;
        tick();
        wvalid = 1'b0;
        chk_cnt++; if ({wready, awready} !== 2'b01) $display("FAIL w_first_ready: got %b want 01", {wready, awready}); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_cnt++; if ({wready, rf_we} !== 2'b00) $display("FAIL w_first_wait: got %b want 00", {wready, rf_we}); else pass_cnt++;
        end
        awaddr = 4'h8; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk_cnt++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'h8, 32'h12345678}) $display("FAIL w_first_we: got %b %h %h want 1 8 12345678", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
        tick();
        chk_cnt++; if (bvalid !== 1'b1) $display("FAIL w_first_bvalid: got %b want 1", bvalid); else pass_cnt++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk_cnt++; if (wr_cnt !== c0 + 1) $display("FAIL w_first_count: got %0d want 1", wr_cnt - c0); else pass_cnt++;
        model_mem[8] = 32'h12345678;
    endtask

    task automatic test_read_backpressure;
        preload(4'hC, 32'hA5A5A5A5);
        araddr = 4'hC; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        chk_cnt++; if ({rf_re, rf_raddr, arready} !== {1'b1, 4'hC, 1'b0}) $display("FAIL rd_bp_re: got %b %h %b want 1 c 0", rf_re, rf_raddr, arready); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_cnt++; if ({rvalid, rdata, rresp, rf_re} !== {1'b1, 32'hA5A5A5A5, 2'b00, 1'b0}) $display("FAIL rd_bp_hold: cycle %0d got %b %h %b want 1 a5a5a5a5 00", i, rvalid, rdata, rresp); else pass_cnt++;
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk_cnt++; if ({rvalid, arready} !== 2'b01) $display("FAIL rd_bp_release: got %b want 01", {rvalid, arready}); else pass_cnt++;
    endtask

    task automatic test_simultaneous;
        logic [31:0] x, y;
        x = $urandom; y = $urandom;
        preload(4'h8, x);
        awaddr = 4'h0; awvalid = 1'b1; wdata = y; wvalid = 1'b1; bready = 1'b1;
        araddr = 4'h8; arvalid = 1'b1; rready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk_cnt++; if ({rf_we, rf_waddr, rf_wdata, rf_re, rf_raddr} !== {1'b1, 4'h0, y, 1'b1, 4'h8}) $display("FAIL simul_strobes: got we=%b %h %h re=%b %h", rf_we, rf_waddr, rf_wdata, rf_re, rf_raddr); else pass_cnt++;
        tick();
        chk_cnt++; if ({bvalid, bresp, rvalid, rresp, rdata} !== {1'b1, 2'b00, 1'b1, 2'b00, x}) $display("FAIL simul_resp: got b=%b %b r=%b %b %h want rdata %h", bvalid, bresp, rvalid, rresp, rdata, x); else pass_cnt++;
        tick();
        bready = 1'b0; rready = 1'b0;
        chk_cnt++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) $display("FAIL simul_idle: got %b want 00111", {bvalid, rvalid, awready, wready, arready}); else pass_cnt++;
        model_mem[0] = y;
    endtask

    task automatic test_unmapped_read;
        logic [31:0] v;
        v = $urandom | 32'h1;
        preload(4'h6, v);
        araddr = 4'h6; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        chk_cnt++; if (rf_re !== !SLV) $display("FAIL unmapped_re: got %b want %b", rf_re, !SLV); else pass_cnt++;
        tick();
        chk_cnt++; if ({rvalid, rresp, rdata} !== {1'b1, SLV ? 2'b10 : 2'b00, SLV ? 32'h0 : v}) $display("FAIL unmapped_resp: got %b %b %h", rvalid, rresp, rdata); else pass_cnt++;
        tick();
        rready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        d = $urandom;
        awaddr = 4'h0; awvalid = 1'b1; wdata = d; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk_cnt++; if (bvalid !== 1'b1) $display("FAIL rstmid_bvalid_before: got %b want 1", bvalid); else pass_cnt++;
        model_mem[0] = d;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if ({bvalid, awready, wready, arready} !== 4'b0000) $display("FAIL rstmid_async: got %b want 0000", {bvalid, awready, wready, arready}); else pass_cnt++;
        tick(); tick();
        rst_n = 1'b1;
        chk_cnt++; if ({awready, wready, arready} !== 3'b000) $display("FAIL rstmid_before_edge: got %b want 000", {awready, wready, arready}); else pass_cnt++;
        tick();
        chk_cnt++; if ({awready, wready, arready, bvalid} !== 4'b1110) $display("FAIL rstmid_release: got %b want 1110", {awready, wready, arready, bvalid}); else pass_cnt++;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input int aw_dly, input int w_dly,
                            input int b_dly, output logic [1:0] resp, output bit ok);
        bit aw_done, w_done, b_done, aw_f, w_f, b_f;
        int cyc;
        aw_done = 0; w_done = 0; b_done = 0; cyc = 0; resp = 2'b11;
        awaddr = a; wdata = d;
        while (!b_done && cyc < 64) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            bready  = (cyc >= b_dly);
            aw_f = awvalid && awready; w_f = wvalid && wready; b_f = bready && bvalid;
            if (b_f) resp = bresp;
            tick();
            aw_done |= aw_f; w_done |= w_f; b_done |= b_f; cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        ok = b_done;
    endtask

    task automatic do_read(input logic [3:0] a, input int r_dly, output logic [31:0] data,
                           output logic [1:0] resp, output bit ok);
        bit ar_done, r_done, ar_f, r_f;
        int cyc;
        ar_done = 0; r_done = 0; cyc = 0; data = 32'h0; resp = 2'b11;
        araddr = a;
        while (!r_done && cyc < 64) begin
            arvalid = !ar_done;
            rready  = (cyc >= r_dly);
            ar_f = arvalid && arready; r_f = rready && rvalid;
            if (r_f) begin data = rdata; resp = rresp; end
            tick();
            ar_done |= ar_f; r_done |= r_f; cyc++;
        end
        arvalid = 1'b0; rready = 1'b0;
        ok = r_done;
    endtask

    task automatic test_random;
        logic [3:0]  a;
        logic [31:0] d, got;
        logic [1:0]  resp;
        bit          ok;
        int          c0;
        for (int i = 0; i < 24; i++) begin
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            c0 = wr_cnt;
            do_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp, ok);
            chk_cnt++; if (!ok) $display("FAIL rand_wr_timeout: iter %0d addr %h", i, a); else pass_cnt++;
            chk_cnt++; if (resp !== (fwd(a) ? 2'b00 : 2'b10)) $display("FAIL rand_bresp: addr %h got %b want %b", a, resp, fwd(a) ? 2'b00 : 2'b10); else pass_cnt++;
            chk_cnt++; if (wr_cnt - c0 !== (fwd(a) ? 1 : 0)) $display("FAIL rand_wr_count: addr %h got %0d want %0d", a, wr_cnt - c0, fwd(a) ? 1 : 0); else pass_cnt++;
            if (fwd(a)) model_mem[a] = d;
            a = 4'($urandom_range(0, 15));
            c0 = rd_cnt;
            do_read(a, $urandom_range(0, 3), got, resp, ok);
            chk_cnt++; if (!ok) $display("FAIL rand_rd_timeout: iter %0d addr %h", i, a); else pass_cnt++;
            chk_cnt++; if ({resp, got} !== {fwd(a) ? 2'b00 : 2'b10, fwd(a) ? model_mem[a] : 32'h0}) $display("FAIL rand_rdata: addr %h got %b %h want %h", a, resp, got, fwd(a) ? model_mem[a] : 32'h0); else pass_cnt++;
            chk_cnt++; if (rd_cnt - c0 !== (fwd(a) ? 1 : 0)) $display("FAIL rand_rd_count: addr %h got %0d want %0d", a, rd_cnt - c0, fwd(a) ? 1 : 0); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_read_backpressure();
        test_simultaneous();
        test_unmapped_read();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/axi_lite_rf_ctrl.md
AXI_LITE_RF_CTRL -- requirements
Module: axi_lite_rf_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 4, byte address width; DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have one clock, i_clock, and an asynchronous active-low reset, i_aresetn; all state is registered on the rising edge of i_clock.
REQ-003 SHALL have ports (name direction width meaning):
- i_clock in 1: clock
- i_aresetn in 1: async reset, active low
- i_awaddr in ADDR_WIDTH: write address
- i_awvalid in 1 / o_awready out 1: AW handshake
- i_wdata in DATA_WIDTH: write data
- i_wvalid in 1 / o_wready out 1: W handshake
- o_bresp out 2 / o_bvalid out 1 / i_bready in 1: B channel
- i_araddr in ADDR_WIDTH: read address
- i_arvalid in 1 / o_arready out 1: AR handshake
- o_rdata out DATA_WIDTH / o_rresp out 2 / o_rvalid out 1 / i_rready in 1: R channel
- o_rf_write_addr out ADDR_WIDTH / o_rf_write_data out DATA_WIDTH / o_rf_write_enable out 1: register-file write port
- o_rf_read_addr out ADDR_WIDTH / o_rf_read_enable out 1 / i_rf_read_data in DATA_WIDTH: register-file read port (combinational read)

Function
REQ-004 SHALL run independent write and read FSMs; both may be active in the same cycle.
REQ-005 Write FSM states SHALL be W_IDLE, W_WRITE, W_RESP.
REQ-006 In W_IDLE, o_awready and o_wready SHALL be high until their own handshake completes; the captured channel then drops its ready. AW and W may complete in either order or in the same cycle.
REQ-007 When both the address and the data are held, the FSM SHALL go to W_WRITE: o_rf_write_enable high for exactly one cycle, carrying the captured address and data.
REQ-008 W_WRITE SHALL go to W_RESP on the next edge: o_bvalid high, o_bresp stable until i_bready; on the B handshake, go to W_IDLE with both readies high.
REQ-009 Latency: AW and W handshake at edge N -> write-enable cycle N+1 -> o_bvalid from edge N+2.
REQ-010 Read FSM states SHALL be R_IDLE, R_READ, R_RESP. In R_IDLE, o_arready is high; the AR handshake captures the address and moves to R_READ.
REQ-011 In R_READ, o_rf_read_enable SHALL be high for one cycle with the captured address, and i_rf_read_data SHALL be registered into o_rdata.
REQ-012 R_RESP SHALL hold o_rvalid, o_rdata and o_rresp stable until i_rready, then return to R_IDLE. AR at edge N -> o_rvalid from edge N+2.
REQ-013 An address is mapped iff addr[1:0]==0 and addr is at most 0xC.
REQ-014 o_rf_write_enable and o_rf_read_enable SHALL be low in every state other than W_WRITE and R_READ respectively.
REQ-015 i_awvalid, i_wvalid and i_arvalid SHALL be ignored when the corresponding ready is low; no transaction is lost or duplicated under back-pressure.

Reset
REQ-016 Asserting i_aresetn low at any time, including mid-transaction, SHALL immediately force both FSMs to idle and drive all outputs to 0, including the readies, both valids, both enables, o_rdata and both resp outputs.
REQ-017 The first rising edge after reset release SHALL raise o_awready, o_wready and o_arready; any transaction in flight when reset was asserted is discarded.

Configuration
REQ-018 Macro AXI_RF_SLVERR_EN SHALL control how unmapped addresses are handled.
- When defined: unmapped write suppresses o_rf_write_enable and returns o_bresp=2'b10; unmapped read suppresses o_rf_read_enable and returns o_rdata=0 with o_rresp=2'b10.
- When undefined: every response is 2'b00, and unmapped accesses are forwarded to the register-file port unchanged.

Verification
REQ-019 Bench SHALL cover:
- AW=0x4 and W=0xDEADBEEF in the same cycle, i_bready=1 -> one write-enable pulse at N+1 with addr 0x4, o_bvalid at N+2, bresp 00.
- W data 0x12345678 three cycles before AW=0x8 -> single write 0x12345678 to 0x8; o_wready low while waiting for AW.
- AR=0xC with register-file data 0xA5A5A5A5, i_rready held low 5 cycles -> o_rvalid and o_rdata held stable 5 cycles, drop one cycle after i_rready.
- Simultaneous write to 0x0 and read of 0x8 -> both complete independently with correct latencies.
- AR=0x6 -> with AXI_RF_SLVERR_EN: rresp 10, rdata 0, no read enable; without: rresp 00.
- i_aresetn pulsed low while in W_RESP -> o_bvalid drops immediately; readies rise on the first edge after release.
